div_arbiter: RTL and testbench

//  Round-robin arbiter/sequencer that shares one FP32 iterative divider (del_fsm) among NREQ requesters.

---
 rtl/div_arbiter.sv | 229 ++++++++++++++++++++++
 tb/tb_div_arbiter.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_arbiter.sv
// div_arbiter: round-robin sequencer sharing one iterative FP32 divider among NREQ requesters.
// Optional build macro DIV_ARB_WDOG_EN adds a watchdog on the WAIT state.
// With the watchdog, a divider that never answers yields qNaN with err_o=1, followed by a re-flush.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// S_FLUSH | count quiet divider cycles after reset (divider has no reset)
// S_IDLE  | pick the next requester round-robin, latch its operands
// S_ISSUE | hold div_r_i high for ISSUE_CYC cycles
// S_WAIT  | wait for div_r_o, capture div_res in that same cycle
// S_RESP  | pulse done_o to the winner, advance the round-robin pointer
module div_arbiter #(
    parameter int NREQ      = 4,
    parameter int ISSUE_CYC = 2,
    parameter int FLUSH_CYC = 255,
    parameter int TIMEOUT   = 1023
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_i,
    input  logic [32*NREQ-1:0]   n_i,
    input  logic [32*NREQ-1:0]   x_i,
    output logic [NREQ-1:0]      gnt_o,
    output logic [NREQ-1:0]      done_o,
    output logic [31:0]          res_o,
    output logic                 err_o,
    output logic [31:0]          div_n,
    output logic [31:0]          div_x,
    output logic                 div_r_i,
    input  logic [31:0]          div_res,
    input  logic                 div_r_o
);

    localparam int PW = $clog2(NREQ);
    localparam int FW = $clog2(FLUSH_CYC + 1);
    localparam int IW = $clog2(ISSUE_CYC + 1);

    typedef enum logic [2:0] {
        S_FLUSH,
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t             r_state;
    state_t             w_state_nx;
    logic [PW-1:0]      r_ptr;
    logic [PW-1:0]      r_cur;
    logic [FW-1:0]      r_flush_cnt;
    logic [IW-1:0]      r_iss_cnt;
    logic [NREQ-1:0]    r_gnt;
    logic [NREQ-1:0]    r_done;
    logic [31:0]        r_res;
    logic [31:0]        r_div_n;
    logic [31:0]        r_div_x;
    logic               r_div_r_i;

    logic               w_found;
    logic [PW-1:0]      w_win;
    logic [PW:0]        w_sum;
    logic [PW-1:0]      w_cand;
    logic [NREQ-1:0]    w_onehot;
    logic [31:0]        w_n_sel;
    logic [31:0]        w_x_sel;
    logic               w_flush_done;
    logic               w_timeout;

`ifdef DIV_ARB_WDOG_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0]      r_wd_cnt;
    logic               r_to;
    logic               r_err;
    assign w_timeout = (r_wd_cnt == TW'(TIMEOUT - 1));
    assign err_o     = r_err;
`else
    assign w_timeout = 1'b0;
    assign err_o     = 1'b0;
`endif

    assign gnt_o   = r_gnt;
    assign done_o  = r_done;
    assign res_o   = r_res;
    assign div_n   = r_div_n;
    assign div_x   = r_div_x;
    assign div_r_i = r_div_r_i;

    assign w_flush_done = (r_flush_cnt == FW'(FLUSH_CYC));

    // Round-robin search: first asserted request after the last winner, wrapping mod NREQ.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_sum   = '0;
        w_cand  = '0;
        for (int i = 1; i <= NREQ; i++) begin
            w_sum  = {1'b0, r_ptr} + (PW+1)'(i);
            w_cand = (w_sum >= (PW+1)'(NREQ)) ? PW'(w_sum - (PW+1)'(NREQ)) : PW'(w_sum);
            if (!w_found && req_i[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    // Operand mux and one-hot grant for the selected winner.
    always_comb begin
        w_n_sel  = '0;
        w_x_sel  = '0;
        w_onehot = '0;
        w_onehot[w_win] = 1'b1;
        for (int k = 0; k < NREQ; k++) begin
            if (w_win == PW'(k)) begin
                w_n_sel = n_i[32*k +: 32];
                w_x_sel = x_i[32*k +: 32];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_FLUSH;
        else     r_state <= w_state_nx;
    end

    // Next-state logic; a late div_r_o takes priority over the watchdog.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_FLUSH: if (!div_r_o && w_flush_done) w_state_nx = S_IDLE;
            S_IDLE:  if (w_found) w_state_nx = S_ISSUE;
            S_ISSUE: if (r_iss_cnt == '0) w_state_nx = S_WAIT;
            S_WAIT:  if (div_r_o || w_timeout) w_state_nx = S_RESP;
`ifdef DIV_ARB_WDOG_EN
            S_RESP:  w_state_nx = r_to ? S_FLUSH : S_IDLE;
`else
            S_RESP:  w_state_nx = S_IDLE;
`endif
            default: w_state_nx = S_FLUSH;
        endcase
    end

    // Flush counter: any divider activity restarts the quiet-period count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flush_cnt <= '0;
        end else if (r_state == S_FLUSH) begin
            if (div_r_o)            r_flush_cnt <= '0;
            else if (!w_flush_done) r_flush_cnt <= r_flush_cnt + FW'(1);
        end else begin
            r_flush_cnt <= '0;
        end
    end

    // Datapath: operand latch, issue strobe, result capture, grant/done handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr     <= PW'(NREQ - 1);
            r_cur     <= '0;
            r_iss_cnt <= '0;
            r_gnt     <= '0;
            r_done    <= '0;
            r_res     <= '0;
            r_div_n   <= '0;
            r_div_x   <= '0;
            r_div_r_i <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_div_n   <= w_n_sel;
                        r_div_x   <= w_x_sel;
                        r_gnt     <= w_onehot;
                        r_cur     <= w_win;
                        r_div_r_i <= 1'b1;
                        r_iss_cnt <= IW'(ISSUE_CYC - 1);
                    end
                end
                S_ISSUE: begin
                    if (r_iss_cnt == '0) r_div_r_i <= 1'b0;
                    else                 r_iss_cnt <= r_iss_cnt - IW'(1);
                end
                S_WAIT: begin
                    if (div_r_o) begin
                        r_res  <= div_res;
                        r_done <= r_gnt;
                    end else if (w_timeout) begin
                        r_res  <= 32'h7FC0_0000;
                        r_done <= r_gnt;
                    end
                end
                S_RESP: begin
                    r_done <= '0;
                    r_gnt  <= '0;
                    r_ptr  <= r_cur;
                end
                default: ;
            endcase
        end
    end

`ifdef DIV_ARB_WDOG_EN
    // Watchdog: counts WAIT cycles, flags the timed-out operation until RESP exits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wd_cnt <= '0;
            r_to     <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_ISSUE: if (r_iss_cnt == '0) r_wd_cnt <= '0;
                S_WAIT: begin
                    if (div_r_o) begin
                        r_err <= 1'b0;
                    end else if (w_timeout) begin
                        r_err <= 1'b1;
                        r_to  <= 1'b1;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + TW'(1);
                    end
                end
                S_RESP: r_to <= 1'b0;
                default: ;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_div_arbiter.sv
// Testbench for div_arbiter: behavioural divider model plus a round-robin reference model.
module tb_div_arbiter;

    localparam int NREQ      = 4;
    localparam int ISSUE_CYC = 2;
    localparam int FLUSH_CYC = 255;
    localparam int TIMEOUT   = 1023;

    // Exact FP32 divisions: 6/2, 1/1, 0.5/1, 10/5, 4/0.5, 100/10
    localparam logic [31:0] TN [6] = '{32'h40C00000, 32'h3F800000, 32'h3F000000,
                                       32'h41200000, 32'h40800000, 32'h42C80000};
    localparam logic [31:0] TX [6] = '{32'h40000000, 32'h3F800000, 32'h3F800000,
                                       32'h40A00000, 32'h3F000000, 32'h41200000};
    localparam logic [31:0] TQ [6] = '{32'h40400000, 32'h3F800000, 32'h3F000000,
                                       32'h40000000, 32'h41000000, 32'h41200000};

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NREQ-1:0]     req_i = '0;
    logic [32*NREQ-1:0]  n_i = '0;
    logic [32*NREQ-1:0]  x_i = '0;
    logic [NREQ-1:0]     gnt_o, done_o;
    logic [31:0]         res_o;
    logic                err_o;
    logic [31:0]         div_n, div_x;
    logic                div_r_i;
    logic [31:0]         div_res = '0;
    logic                div_r_o = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    int m_last;
    int op_of [NREQ];
    logic mdl_hang = 1'b0;

    div_arbiter #(.NREQ(NREQ), .ISSUE_CYC(ISSUE_CYC), .FLUSH_CYC(FLUSH_CYC), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .n_i(n_i), .x_i(x_i),
        .gnt_o(gnt_o), .done_o(done_o), .res_o(res_o), .err_o(err_o),
        .div_n(div_n), .div_x(div_x), .div_r_i(div_r_i),
        .div_res(div_res), .div_r_o(div_r_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] div_lookup(input logic [31:0] n, input logic [31:0] x);
        for (int i = 0; i < 6; i++)
            if (TN[i] == n && TX[i] == x) return TQ[i];
        return n ^ x;
    endfunction

    // Divider model: starts on a rising div_r_i, answers after a random latency with a
    // one-cycle div_r_o, clears div_res afterwards; it has no reset.
    initial begin : divider_model
        logic        busy = 1'b0;
        logic        prev = 1'b0;
        int          cnt  = 0;
        logic [31:0] q    = '0;
        forever begin
            @(negedge clk);
            if (div_r_o) begin
                div_r_o = 1'b0;
                div_res = '0;
            end
            if (busy) begin
                if (cnt == 0) begin
                    if (!mdl_hang) begin
                        div_r_o = 1'b1;
                        div_res = q;
                    end
                    busy = 1'b0;
                end else begin
                    cnt--;
                end
            end else if (div_r_i && !prev) begin
                busy = 1'b1;
                cnt  = $urandom_range(20, 6);
                q    = div_lookup(div_n, div_x);
            end
            prev = div_r_i;
        end
    end

    initial begin : global_guard
        #3_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    function automatic int ref_pick(input logic [NREQ-1:0] m, input int last);
        for (int d = 1; d <= NREQ; d++)
            if (m[(last + d) % NREQ]) return (last + d) % NREQ;
        return -1;
    endfunction

    task automatic set_req(input int k, input int op);
        n_i[32*k +: 32] = TN[op];
        x_i[32*k +: 32] = TX[op];
        op_of[k] = op;
        req_i[k] = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_i = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        m_last = NREQ - 1;
    endtask

    task automatic wait_done(input int budget, output logic got, output logic [NREQ-1:0] d,
                             output logic [31:0] r, output logic e);
        got = 1'b0; d = '0; r = '0; e = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (done_o != '0) begin
                got = 1'b1; d = done_o; r = res_o; e = err_o;
            end
        end
    endtask

    task automatic wait_gnt(input int budget, output logic got);
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (gnt_o != '0) got = 1'b1;
        end
    endtask

    task automatic wait_issue_end(input int budget, output logic got);
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (!div_r_i) got = 1'b1;
        end
    endtask

    task automatic test_reset();
        int bad_cyc = 0;
        int first   = -1;
        @(negedge clk);
        n_cmp++;
        if ({gnt_o, done_o, res_o, err_o, div_n, div_x, div_r_i} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got gnt=%b done=%b res=%h err=%b r_i=%b, expected all 0",
                     gnt_o, done_o, res_o, err_o, div_r_i);
        end
        rst = 1'b0;
        m_last = NREQ - 1;
        set_req(0, 0);
        for (int c = 1; c <= FLUSH_CYC + 20 && first < 0; c++) begin
            @(negedge clk);
            if (gnt_o != '0) first = c;
            else if ({done_o, res_o, err_o, div_n, div_x, div_r_i} !== '0) bad_cyc++;
        end
        n_cmp++;
        if (bad_cyc != 0) begin
            n_bad++;
            $display("FAIL flush_quiet: got %0d cycles with active outputs, expected 0", bad_cyc);
        end
        n_cmp++;
        if (first < FLUSH_CYC + 1 || first > FLUSH_CYC + 3) begin
            n_bad++;
            $display("FAIL first_gnt_time: got cycle %0d, expected %0d..%0d", first, FLUSH_CYC + 1, FLUSH_CYC + 3);
        end
    endtask

    task automatic test_single();
        int hi = 1;
        logic got;
        logic [NREQ-1:0] d;
        logic [31:0] r;
        logic e;
        n_cmp++;
        if (gnt_o !== 4'b0001 || div_r_i !== 1'b1) begin
            n_bad++;
            $display("FAIL single_grant: got gnt=%b r_i=%b, expected gnt=0001 r_i=1", gnt_o, div_r_i);
        end
        n_cmp++;
        if (div_n !== TN[0] || div_x !== TX[0]) begin
            n_bad++;
            $display("FAIL single_operands: got n=%h x=%h, expected n=%h x=%h", div_n, div_x, TN[0], TX[0]);
        end
        for (int i = 0; i < 10 && div_r_i; i++) begin
            @(negedge clk);
            if (div_r_i) hi++;
        end
        n_cmp++;
        if (hi != ISSUE_CYC) begin
            n_bad++;
            $display("FAIL issue_len: got %0d cycles, expected %0d", hi, ISSUE_CYC);
        end
        wait_done(200, got, d, r, e);
        n_cmp++;
        if (!got || d !== 4'b0001 || r !== 32'h40400000 || e !== 1'b0) begin
            n_bad++;
            $display("FAIL single_done: got seen=%b done=%b res=%h err=%b, expected done=0001 res=40400000 err=0",
                     got, d, r, e);
        end
        req_i[0] = 1'b0;
        m_last = 0;
        @(negedge clk);
        n_cmp++;
        if (done_o !== '0 || gnt_o !== '0 || res_o !== 32'h40400000) begin
            n_bad++;
            $display("FAIL single_after: got done=%b gnt=%b res=%h, expected done=0 gnt=0 res=40400000",
                     done_o, gnt_o, res_o);
        end
    endtask

    task automatic test_round_robin();
        int order [5] = '{0, 1, 2, 3, 0};
        logic got;
        logic [NREQ-1:0] d, exp_d;
        logic [31:0] r;
        logic e;
        do_reset();
        set_req(0, 1);
        set_req(1, 2);
        set_req(2, 0);
        set_req(3, 3);
        for (int j = 0; j < 5; j++) begin
            exp_d = '0;
            exp_d[order[j]] = 1'b1;
            wait_done(600, got, d, r, e);
            n_cmp++;
            if (!got || d !== exp_d || r !== TQ[op_of[order[j]]] || e !== 1'b0) begin
                n_bad++;
                $display("FAIL rr_op%0d: got seen=%b done=%b res=%h err=%b, expected done=%b res=%h err=0",
                         j, got, d, r, e, exp_d, TQ[op_of[order[j]]]);
            end
            req_i[order[j]] = 1'b0;
            m_last = order[j];
            @(negedge clk);
            if (j < 4) set_req(order[j], op_of[order[j]]);
        end
        req_i = '0;
    endtask

    task automatic test_abort();
        logic got, got2;
        logic [NREQ-1:0] d;
        logic [31:0] r;
        logic e;
        set_req(0, 4);
        wait_gnt(50, got);
        wait_issue_end(10, got2);
        n_cmp++;
        if (!got || !got2) begin
            n_bad++;
            $display("FAIL abort_reach_wait: got gnt_seen=%b wait_seen=%b, expected 1 1", got, got2);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({gnt_o, done_o, res_o, err_o, div_n, div_x, div_r_i} !== '0) begin
            n_bad++;
            $display("FAIL abort_clear: got gnt=%b done=%b res=%h r_i=%b, expected all 0",
                     gnt_o, done_o, res_o, div_r_i);
        end
        @(negedge clk);
        rst = 1'b0;
        req_i = '0;
        m_last = NREQ - 1;
        set_req(1, 2);
        wait_done(700, got, d, r, e);
        n_cmp++;
        if (!got || d !== 4'b0010 || r !== 32'h3F000000 || e !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_next: got seen=%b done=%b res=%h err=%b, expected done=0010 res=3f000000 err=0",
                     got, d, r, e);
        end
        req_i[1] = 1'b0;
        m_last = 1;
    endtask

    task automatic test_drop();
        logic got, got2;
        logic [NREQ-1:0] d, exp_d;
        logic [31:0] r;
        logic e;
        int extra = 0;
        set_req(2, 5);
        exp_d = '0;
        exp_d[ref_pick(req_i, m_last)] = 1'b1;
        wait_gnt(50, got);
        n_cmp++;
        if (!got || gnt_o !== exp_d) begin
            n_bad++;
            $display("FAIL drop_grant: got seen=%b gnt=%b, expected %b", got, gnt_o, exp_d);
        end
        wait_issue_end(10, got2);
        req_i[2] = 1'b0;
        wait_done(100, got, d, r, e);
        n_cmp++;
        if (!got || d !== 4'b0100 || r !== TQ[5]) begin
            n_bad++;
            $display("FAIL drop_done: got seen=%b done=%b res=%h, expected done=0100 res=%h", got, d, r, TQ[5]);
        end
        m_last = 2;
        repeat (30) begin
            @(negedge clk);
            if (gnt_o != '0 || done_o != '0) extra++;
        end
        n_cmp++;
        if (extra != 0) begin
            n_bad++;
            $display("FAIL drop_no_regrant: got %0d active cycles, expected 0", extra);
        end
    endtask

    task automatic test_random();
        int pred;
        logic got;
        logic [NREQ-1:0] d, exp_d, mask;
        logic [31:0] r;
        logic e;
        for (int op = 0; op < 24; op++) begin
            if (req_i == '0) begin
                repeat ($urandom_range(3, 0)) @(negedge clk);
                mask = NREQ'($urandom_range(15, 1));
                for (int k = 0; k < NREQ; k++)
                    if (mask[k]) set_req(k, $urandom_range(5, 0));
            end
            pred = ref_pick(req_i, m_last);
            exp_d = '0;
            exp_d[pred] = 1'b1;
            wait_done(200, got, d, r, e);
            n_cmp++;
            if (!got || d !== exp_d || r !== TQ[op_of[pred]] || e !== 1'b0) begin
                n_bad++;
                $display("FAIL random_op%0d: got seen=%b done=%b res=%h err=%b, expected done=%b res=%h err=0",
                         op, got, d, r, e, exp_d, TQ[op_of[pred]]);
            end
            m_last = pred;
            req_i[pred] = 1'b0;
            for (int k = 0; k < NREQ; k++)
                if (k != pred && !req_i[k] && $urandom_range(1, 0) == 1) set_req(k, $urandom_range(5, 0));
        end
        while (req_i != '0) begin
            pred = ref_pick(req_i, m_last);
            wait_done(200, got, d, r, e);
            n_cmp++;
            if (!got || d[pred] !== 1'b1) begin
                n_bad++;
                $display("FAIL random_drain: got seen=%b done=%b, expected bit %0d", got, d, pred);
            end
            m_last = pred;
            req_i[pred] = 1'b0;
        end
    endtask

`ifdef DIV_ARB_WDOG_EN
    task automatic test_wdog();
        logic got, got2;
        logic [NREQ-1:0] d;
        logic [31:0] r;
        logic e;
        int c = 0;
        int g = 0;
        mdl_hang = 1'b1;
        set_req(3, 0);
        wait_gnt(50, got);
        wait_issue_end(10, got2);
        got = 1'b0;
        for (int i = 0; i < TIMEOUT + 20 && !got; i++) begin
            @(negedge clk);
            c++;
            if (done_o != '0) begin
                got = 1'b1; d = done_o; r = res_o; e = err_o;
            end
        end
        n_cmp++;
        if (!got || c != TIMEOUT || d !== 4'b1000 || r !== 32'h7FC00000 || e !== 1'b1) begin
            n_bad++;
            $display("FAIL wdog_done: got seen=%b cyc=%0d done=%b res=%h err=%b, expected cyc=%0d done=1000 res=7fc00000 err=1",
                     got, c, d, r, e, TIMEOUT);
        end
        req_i[3] = 1'b0;
        m_last = 3;
        mdl_hang = 1'b0;
        set_req(0, 1);
        got = 1'b0;
        for (int i = 0; i < FLUSH_CYC + 20 && !got; i++) begin
            @(negedge clk);
            g++;
            if (gnt_o != '0) got = 1'b1;
        end
        n_cmp++;
        if (!got || g < FLUSH_CYC) begin
            n_bad++;
            $display("FAIL wdog_reflush: got seen=%b after %0d cycles, expected >= %0d", got, g, FLUSH_CYC);
        end
        wait_done(100, got, d, r, e);
        n_cmp++;
        if (!got || d !== 4'b0001 || r !== TQ[1] || e !== 1'b0) begin
            n_bad++;
            $display("FAIL wdog_recover: got seen=%b done=%b res=%h err=%b, expected done=0001 res=%h err=0",
                     got, d, r, e, TQ[1]);
        end
        req_i[0] = 1'b0;
        m_last = 0;
    endtask
`endif

    initial begin
        for (int k = 0; k < NREQ; k++) op_of[k] = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_abort();
        test_drop();
        test_random();
`ifdef DIV_ARB_WDOG_EN
        test_wdog();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
